// File: rtl/serializer_pkg.sv
// Shared types and helpers for serializer_param: FSM state encoding,
// word-length decode and length legality check.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // A length field of 0 stands for a full-width word.
  function automatic int decode_len(input int mod, input int data_w);
    return (mod == 0) ? data_w : mod;
  endfunction

  // Words shorter than min_len are rejected instead of serialized.
  function automatic logic is_legal_len(input int len, input int min_len);
    return (len >= min_len);
  endfunction

endpackage

// File: rtl/serializer_param.sv
// Parametrised parallel-to-serial converter with a valid/ready input,
// programmable word length and per-word bit order. Back-to-back words
// stream with no idle cycle between them.
// Optional: define SERIALIZER_PARITY_EN to append an even-parity bit to
// every word (sent in state PARITY, which then carries ser_last_o).
module serializer_param
  import serializer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              msb_first_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              busy_o,
  output logic              drop_o
);

  localparam int CNT_W = MOD_W + 1;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                msb_q, msb_d;
  logic                ser_data_q, ser_data_d;
  logic                ser_val_q, ser_val_d;
  logic                ser_last_q, ser_last_d;
  logic                drop_q, drop_d;
`ifdef SERIALIZER_PARITY_EN
  logic                par_q, par_d;
`endif

  logic [CNT_W-1:0]    len;
  logic                legal;
  logic                accept;
  logic                first_bit;
  logic                next_bit;
  logic                finish;

  assign len       = CNT_W'(decode_len(32'(data_mod_i), DATA_W));
  assign legal     = is_legal_len(32'(len), MIN_LEN);
  assign accept    = data_val_i & data_rdy_o;
  assign first_bit = msb_first_i ? data_i[DATA_W-1] : data_i[0];
  assign next_bit  = msb_q ? shreg_q[DATA_W-1] : shreg_q[0];

  // Next-state: shift the current word, close it out, then let a new
  // accept (only possible in IDLE or on the final bit) override the close.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    msb_d      = msb_q;
    ser_data_d = ser_data_q;
    ser_val_d  = ser_val_q;
    ser_last_d = ser_last_q;
    drop_d     = 1'b0;
    finish     = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (cnt_q != '0) begin
          ser_data_d = next_bit;
          shreg_d    = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_d      = cnt_q - CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
          par_d      = par_q ^ next_bit;
          ser_last_d = 1'b0;
`else
          ser_last_d = (cnt_q == CNT_W'(1));
`endif
        end else begin
`ifdef SERIALIZER_PARITY_EN
          state_d    = PARITY;
          ser_data_d = par_q;
          ser_last_d = 1'b1;
`else
          finish     = 1'b1;
`endif
        end
      end
      default: finish = 1'b1;
    endcase

    if (finish) begin
      state_d    = IDLE;
      ser_data_d = 1'b0;
      ser_val_d  = 1'b0;
      ser_last_d = 1'b0;
    end

    if (accept) begin
      if (legal) begin
        state_d    = SHIFT;
        msb_d      = msb_first_i;
        shreg_d    = msb_first_i ? (data_i << 1) : (data_i >> 1);
        cnt_d      = len - CNT_W'(1);
        ser_data_d = first_bit;
        ser_val_d  = 1'b1;
`ifdef SERIALIZER_PARITY_EN
        par_d      = first_bit;
        ser_last_d = 1'b0;
`else
        ser_last_d = (len == CNT_W'(1));
`endif
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // State and registered outputs; reset discards any word in flight.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      msb_q      <= 1'b0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      ser_last_q <= 1'b0;
      drop_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      msb_q      <= msb_d;
      ser_data_q <= ser_data_d;
      ser_val_q  <= ser_val_d;
      ser_last_q <= ser_last_d;
      drop_q     <= drop_d;
`ifdef SERIALIZER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign data_rdy_o     = (state_q == IDLE) | ser_last_q;
  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign ser_last_o     = ser_last_q;
  assign busy_o         = ser_val_q;
  assign drop_o         = drop_q;

endmodule

// File: tb/tb_serializer_param.sv
// Directed, table-driven bench for serializer_param (DATA_W=16).
// Follows SERIALIZER_PARITY_EN when the same define is given to the bench.
module tb_serializer_param;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic [MOD_W-1:0]  data_mod_i = '0;
  logic              msb_first_i = 1'b0;
  logic              data_val_i = 1'b0;
  logic              data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, busy_o, drop_o;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  serializer_param #(.DATA_W(DATA_W), .MOD_W(MOD_W), .MIN_LEN(3)) dut (
    .clk_i(clk), .arstn_i(arstn), .data_i(data_i), .data_mod_i(data_mod_i),
    .msb_first_i(msb_first_i), .data_val_i(data_val_i), .data_rdy_o(data_rdy_o),
    .ser_data_o(ser_data_o), .ser_data_val_o(ser_data_val_o), .ser_last_o(ser_last_o),
    .busy_o(busy_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // exp holds the transmitted bits in order: first bit is exp[len-1].
  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    logic        msb;
    int          len;
    logic [15:0] exp;
    logic        drop;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] m, input logic msb);
    data_i      = d;
    data_mod_i  = m;
    msb_first_i = msb;
    data_val_i  = 1'b1;
  endtask

  task automatic expect_bit(input string name, input logic b, input logic last);
    @(negedge clk);
    chk({name, " val"},  32'(ser_data_val_o), 32'd1);
    chk({name, " busy"}, 32'(busy_o), 32'd1);
    chk({name, " data"}, 32'(ser_data_o), 32'(b));
    chk({name, " last"}, 32'(ser_last_o), 32'(last));
    chk({name, " rdy"},  32'(data_rdy_o), 32'(last));
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    chk({name, " val"},  32'(ser_data_val_o), 32'd0);
    chk({name, " busy"}, 32'(busy_o), 32'd0);
    chk({name, " last"}, 32'(ser_last_o), 32'd0);
    chk({name, " data"}, 32'(ser_data_o), 32'd0);
    chk({name, " drop"}, 32'(drop_o), 32'd0);
    chk({name, " rdy"},  32'(data_rdy_o), 32'd1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    drive(v.data, v.mod, v.msb);
    if (v.drop) begin
      @(negedge clk);
      data_val_i = 1'b0;
      chk({name, " drop"}, 32'(drop_o), 32'd1);
      chk({name, " val"},  32'(ser_data_val_o), 32'd0);
      chk({name, " rdy"},  32'(data_rdy_o), 32'd1);
      expect_idle({name, " after"});
    end else begin
      for (int i = 0; i < v.len; i++) begin
        expect_bit($sformatf("%s b%0d", name, i), v.exp[v.len-1-i], (i == v.len-1) && !PAR);
        if (i == 0) data_val_i = 1'b0;
      end
`ifdef SERIALIZER_PARITY_EN
      expect_bit({name, " par"}, ^v.exp, 1'b1);
`endif
      expect_idle({name, " end"});
    end
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 4'd0,  1'b1, 16, 16'hA5C3, 1'b0};
    vecs[1] = '{16'hA5C3, 4'd0,  1'b0, 16, 16'hC3A5, 1'b0};
    vecs[2] = '{16'h1234, 4'd8,  1'b1, 8,  16'h0012, 1'b0};
    vecs[3] = '{16'h00B4, 4'd6,  1'b0, 6,  16'h000B, 1'b0};
    vecs[4] = '{16'hFFFF, 4'd3,  1'b0, 3,  16'h0007, 1'b0};
    vecs[5] = '{16'h8001, 4'd15, 1'b1, 15, 16'h4000, 1'b0};
    vecs[6] = '{16'hE000, 4'd3,  1'b1, 3,  16'h0007, 1'b0};
    vecs[7] = '{16'hFFFF, 4'd1,  1'b1, 0,  16'h0000, 1'b1};
    vecs[8] = '{16'hFFFF, 4'd2,  1'b0, 0,  16'h0000, 1'b1};

    // Reset state, then release
    repeat (2) @(negedge clk);
    chk("rst val",  32'(ser_data_val_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst last", 32'(ser_last_o), 32'd0);
    chk("rst drop", 32'(drop_o), 32'd0);
    chk("rst data", 32'(ser_data_o), 32'd0);
    arstn = 1'b1;
    expect_idle("idle");

    foreach (vecs[k]) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Back-to-back: 5-bit MSB-first then 4-bit LSB-first, no gap
    drive(16'hF800, 4'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      expect_bit($sformatf("b2b w0 b%0d", i), 1'b1, (i == 4) && !PAR);
      if (i == 0) data_val_i = 1'b0;
    end
`ifdef SERIALIZER_PARITY_EN
    expect_bit("b2b w0 par", 1'b1, 1'b1);
`endif
    drive(16'h0006, 4'd4, 1'b0);
    begin
      logic [3:0] e;
      e = 4'b0110;
      for (int i = 0; i < 4; i++) begin
        expect_bit($sformatf("b2b w1 b%0d", i), e[3-i], (i == 3) && !PAR);
        if (i == 0) data_val_i = 1'b0;
      end
    end
`ifdef SERIALIZER_PARITY_EN
    expect_bit("b2b w1 par", 1'b0, 1'b1);
`endif
    expect_idle("b2b end");

    // Illegal word offered on the final bit: current word ends, block idles
    drive(16'hFFFF, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_bit($sformatf("rej b%0d", i), 1'b1, (i == 2) && !PAR);
      if (i == 0) data_val_i = 1'b0;
    end
`ifdef SERIALIZER_PARITY_EN
    expect_bit("rej par", 1'b1, 1'b1);
`endif
    drive(16'hFFFF, 4'd2, 1'b1);
    @(negedge clk);
    data_val_i = 1'b0;
    chk("rej drop", 32'(drop_o), 32'd1);
    chk("rej val",  32'(ser_data_val_o), 32'd0);
    chk("rej rdy",  32'(data_rdy_o), 32'd1);
    expect_idle("rej end");

    // Reset on the 7th bit of a 16-bit word
    drive(16'hFFFF, 4'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      expect_bit($sformatf("mid b%0d", i), 1'b1, 1'b0);
      if (i == 0) data_val_i = 1'b0;
    end
    #2 arstn = 1'b0;
    #1;
    chk("mid rst val",  32'(ser_data_val_o), 32'd0);
    chk("mid rst busy", 32'(busy_o), 32'd0);
    chk("mid rst data", 32'(ser_data_o), 32'd0);
    chk("mid rst last", 32'(ser_last_o), 32'd0);
    chk("mid rst rdy",  32'(data_rdy_o), 32'd1);
    @(negedge clk);
    arstn = 1'b1;
    expect_idle("post rst");
    run_vec("post rst w", '{16'h5A00, 4'd8, 1'b1, 8, 16'h005A, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
